seven_seg_scan: RTL



---
 rtl/seven_seg_scan.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for common-anode 7-segment displays: scans NUM_DIGITS hex
// digits with PWM brightness, leading-zero blanking and a frame-synchronous double buffer.
module seven_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     bright,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        div_cnt_reg;
    logic [IDX_W-1:0]        digit_idx_reg;
    logic [BRIGHT_W-1:0]     pwm_cnt_reg;
    logic [4*NUM_DIGITS-1:0] shadow_val_reg;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg;
    logic [4*NUM_DIGITS-1:0] active_val_reg;
    logic [NUM_DIGITS-1:0]   active_dp_reg;
    logic                    pending_reg;
    logic                    active_valid_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic [6:0]              seg_reg;
    logic                    dp_reg;
    logic                    frame_start_reg;

    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;

    logic                    div_wrap;
    logic                    frame_boundary;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [3:0]              digit_nib [NUM_DIGITS];
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    pwm_on;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign div_wrap       = (div_cnt_reg == DIV_LAST);
    assign frame_boundary = div_wrap && (digit_idx_reg == IDX_LAST);
    assign pwm_on         = (pwm_cnt_reg <= bright);

    // upper_zero[i]: nibbles i..NUM_DIGITS-1 of the active buffer are all zero
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_sel[gi]  = (digit_idx_reg == IDX_W'(gi));
        assign digit_nib[gi]  = active_val_reg[4*gi +: 4];
        assign upper_zero[gi] = ~|active_val_reg[4*NUM_DIGITS-1:4*gi];
    end

    always_comb begin
        cur_nib = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel[i]) begin
                cur_nib = digit_nib[i];
            end
        end
        cur_dp    = |(active_dp_reg & digit_sel);
        cur_blank = blank_lz && !digit_sel[0] && |(upper_zero & digit_sel);

        seg_next = cur_blank ? 7'h7F : hex_to_seg(cur_nib);
        dp_next  = ~cur_dp;
        an_next  = '1;
        // A blanked digit still lights its anode when its decimal point is requested
        if (active_valid_reg && pwm_on && (!cur_blank || cur_dp)) begin
            an_next = ~digit_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg      <= '0;
            digit_idx_reg    <= '0;
            pwm_cnt_reg      <= '0;
            shadow_val_reg   <= '0;
            shadow_dp_reg    <= '0;
            active_val_reg   <= '0;
            active_dp_reg    <= '0;
            pending_reg      <= 1'b0;
            active_valid_reg <= 1'b0;
            an_reg           <= '1;
            seg_reg          <= 7'h7F;
            dp_reg           <= 1'b1;
            frame_start_reg  <= 1'b0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;

            if (div_wrap) begin
                div_cnt_reg   <= '0;
                digit_idx_reg <= (digit_idx_reg == IDX_LAST) ? '0 : digit_idx_reg + 1'b1;
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end

            if (frame_boundary && pending_reg) begin
                active_val_reg   <= shadow_val_reg;
                active_dp_reg    <= shadow_dp_reg;
                active_valid_reg <= 1'b1;
            end

            // A load on the boundary cycle lands in shadow and stays pending for the next frame
            if (load) begin
                shadow_val_reg <= value;
                shadow_dp_reg  <= dp_in;
                pending_reg    <= 1'b1;
            end else if (frame_boundary) begin
                pending_reg <= 1'b0;
            end

            an_reg          <= an_next;
            seg_reg         <= seg_next;
            dp_reg          <= dp_next;
            frame_start_reg <= frame_boundary;
        end
    end

    assign an          = an_reg;
    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign frame_start = frame_start_reg;

endmodule
